// File: rtl/regs_wr_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : regs_wr_arbiter_if                                         |
// | Brief    : Bus bundle for the register-file write-port arbiter:      |
// |            two writeback requesters, the write port, hazard query.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface regs_wr_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic [AW-1:0] hz_addr;
  logic          hz_pending;
  logic          idle;
  logic [7:0]    drop_cnt;

  // Requesters, stall logic and register file side
  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, hz_addr,
    input  a_ready, b_ready, rf_we, rf_addr, rf_data, hz_pending, idle, drop_cnt
  );

  // Arbiter side
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, hz_addr,
    output a_ready, b_ready, rf_we, rf_addr, rf_data, hz_pending, idle, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/regs_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : regs_wr_arbiter                                            |
// | Brief    : Shares the register file write port between the ALU (A)  |
// |            and load (B) writeback paths. Each side has a DEPTH-entry |
// |            FIFO; a round-robin arbiter drains one entry per cycle    |
// |            into a registered write stage. Address-0 writes are       |
// |            dropped and counted. Hazard query reports in-flight regs. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module regs_wr_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic              clk,
  input  logic              rst,
  regs_wr_arbiter_if.slave  bus
);

  localparam int         c_NREQ     = 2;
  localparam int         c_PTR_W    = $clog2(DEPTH);
  localparam int         c_CNT_W    = c_PTR_W + 1;
  localparam logic [7:0] c_DROP_MAX = 8'hFF;

  // Index 0 is requester A, index 1 is requester B
  logic [c_NREQ-1:0]         w_in_valid;
  logic [c_NREQ-1:0][AW-1:0] w_in_addr;
  logic [c_NREQ-1:0][DW-1:0] w_in_data;
  logic [c_NREQ-1:0]         w_push;
  logic [c_NREQ-1:0]         w_pop;
  logic [c_NREQ-1:0]         w_empty;
  logic [c_NREQ-1:0]         w_full;
  logic [c_NREQ-1:0]         w_hit;
  logic [c_NREQ-1:0][AW-1:0] w_head_addr;
  logic [c_NREQ-1:0][DW-1:0] w_head_data;

  logic          w_grant;
  logic          w_sel_b;
  logic [AW-1:0] w_win_addr;
  logic [DW-1:0] w_win_data;

  logic          r_last_b;
  logic          r_rf_we;
  logic [AW-1:0] r_rf_addr;
  logic [DW-1:0] r_rf_data;
  logic [7:0]    r_drop_cnt;

  assign w_in_valid = {bus.b_valid, bus.a_valid};
  assign w_in_addr  = {bus.b_addr,  bus.a_addr};
  assign w_in_data  = {bus.b_data,  bus.a_data};

  for (genvar gi = 0; gi < c_NREQ; gi++) begin : g_fifo
    logic [AW-1:0]      r_mem_addr [DEPTH];
    logic [DW-1:0]      r_mem_data [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_hit_any;

    // Ready depends only on occupancy, so a full FIFO refuses even while popping
    assign w_empty[gi]     = (r_count == '0);
    assign w_full[gi]      = (r_count == c_CNT_W'(DEPTH));
    assign w_push[gi]      = w_in_valid[gi] & ~w_full[gi];
    assign w_head_addr[gi] = r_mem_addr[r_rd_ptr];
    assign w_head_data[gi] = r_mem_data[r_rd_ptr];

    // Entry storage; only slots inside the occupancy window are ever read
    always_ff @(posedge clk) begin
      if (w_push[gi]) begin
        r_mem_addr[r_wr_ptr] <= w_in_addr[gi];
        r_mem_data[r_wr_ptr] <= w_in_data[gi];
      end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push[gi]) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        if (w_pop[gi])  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        case ({w_push[gi], w_pop[gi]})
          2'b10:   r_count <= r_count + c_CNT_W'(1);
          2'b01:   r_count <= r_count - c_CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end

    // Scan live entries (offset from read pointer below occupancy) for the queried register
    always_comb begin
      w_hit_any = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (({1'b0, c_PTR_W'(j) - r_rd_ptr} < r_count) && (r_mem_addr[j] == bus.hz_addr))
          w_hit_any = 1'b1;
      end
    end

    assign w_hit[gi] = w_hit_any;
  end

  // Round-robin: a lone non-empty side wins; on contention the side not granted last wins
  assign w_grant    = ~w_empty[0] | ~w_empty[1];
  assign w_sel_b    = ~w_empty[1] & (w_empty[0] | ~r_last_b);
  assign w_pop[0]   = ~w_empty[0] & ~w_sel_b;
  assign w_pop[1]   = ~w_empty[1] &  w_sel_b;
  assign w_win_addr = w_sel_b ? w_head_addr[1] : w_head_addr[0];
  assign w_win_data = w_sel_b ? w_head_data[1] : w_head_data[0];

  // Registered write stage; address-0 heads are consumed without a write and counted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_b   <= 1'b1;
      r_rf_we    <= 1'b0;
      r_rf_addr  <= '0;
      r_rf_data  <= '0;
      r_drop_cnt <= '0;
    end else if (w_grant) begin
      r_last_b  <= w_sel_b;
      r_rf_we   <= (w_win_addr != '0);
      r_rf_addr <= w_win_addr;
      r_rf_data <= w_win_data;
      if ((w_win_addr == '0) && (r_drop_cnt != c_DROP_MAX))
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end else begin
      r_rf_we <= 1'b0;
    end
  end

  assign bus.a_ready    = ~w_full[0] & ~rst;
  assign bus.b_ready    = ~w_full[1] & ~rst;
  assign bus.rf_we      = r_rf_we;
  assign bus.rf_addr    = r_rf_addr;
  assign bus.rf_data    = r_rf_data;
  assign bus.drop_cnt   = r_drop_cnt;
  assign bus.idle       = w_empty[0] & w_empty[1] & ~r_rf_we;
  assign bus.hz_pending = (bus.hz_addr != '0) &
                          ((|w_hit) | (r_rf_we & (r_rf_addr == bus.hz_addr)));

endmodule
`default_nettype wire

// File: tb/tb_regs_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_regs_wr_arbiter                                         |
// | Brief    : Self-checking bench for regs_wr_arbiter: directed steps   |
// |            followed by random traffic against a queue-based model.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_regs_wr_arbiter;
  localparam int DEPTH = 2;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic clk;
  logic rst;

  regs_wr_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  regs_wr_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  // Reference model: per-requester queues plus the expected write-port register
  wr_t           qa[$];
  wr_t           qb[$];
  bit            m_last_b;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_drop;

  int    checks = 0;
  int    errors = 0;
  bit    acc_a, acc_b;
  string phase;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_last_b = 1'b1;
    m_we     = 1'b0;
    m_addr   = '0;
    m_data   = '0;
    m_drop   = 0;
  endtask

  function automatic bit m_hz(input logic [AW-1:0] h);
    if (h == 0) return 1'b0;
    foreach (qa[k]) if (qa[k].addr == h) return 1'b1;
    foreach (qb[k]) if (qb[k].addr == h) return 1'b1;
    return m_we && (m_addr == h);
  endfunction

  task automatic check_all();
    chk({phase, "/a_ready"},    64'(bus.a_ready),    64'(qa.size() < DEPTH));
    chk({phase, "/b_ready"},    64'(bus.b_ready),    64'(qb.size() < DEPTH));
    chk({phase, "/rf_we"},      64'(bus.rf_we),      64'(m_we));
    chk({phase, "/rf_addr"},    64'(bus.rf_addr),    64'(m_addr));
    chk({phase, "/rf_data"},    64'(bus.rf_data),    64'(m_data));
    chk({phase, "/drop_cnt"},   64'(bus.drop_cnt),   64'(m_drop));
    chk({phase, "/idle"},       64'(bus.idle),       64'(qa.size() == 0 && qb.size() == 0 && !m_we));
    chk({phase, "/hz_pending"}, 64'(bus.hz_pending), 64'(m_hz(bus.hz_addr)));
  endtask

  // One clock: check settled outputs, then apply the spec's pop/push rules at the edge.
  // Entered and left just after a falling edge.
  task automatic cycle();
    bit  ra, rb, ga, gb;
    wr_t h, e;
    #1;
    check_all();
    ra    = qa.size() < DEPTH;
    rb    = qb.size() < DEPTH;
    ga    = (qa.size() > 0) && ((qb.size() == 0) || m_last_b);
    gb    = !ga && (qb.size() > 0);
    acc_a = bus.a_valid && ra;
    acc_b = bus.b_valid && rb;
    @(posedge clk);
    if (ga || gb) begin
      if (ga) h = qa.pop_front();
      else    h = qb.pop_front();
      m_last_b = gb;
      m_we     = (h.addr != 0);
      m_addr   = h.addr;
      m_data   = h.data;
      if (h.addr == 0 && m_drop < 255) m_drop++;
    end else begin
      m_we = 1'b0;
    end
    if (acc_a) begin e.addr = bus.a_addr; e.data = bus.a_data; qa.push_back(e); end
    if (acc_b) begin e.addr = bus.b_addr; e.data = bus.b_data; qb.push_back(e); end
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic async_reset();
    drive_idle();
    #2;
    rst = 1'b1;
    #1;
    chk({phase, "/rst_rf_we"},   64'(bus.rf_we),    64'd0);
    chk({phase, "/rst_a_ready"}, 64'(bus.a_ready),  64'd0);
    chk({phase, "/rst_b_ready"}, 64'(bus.b_ready),  64'd0);
    chk({phase, "/rst_rf_addr"}, 64'(bus.rf_addr),  64'd0);
    chk({phase, "/rst_drop"},    64'(bus.drop_cnt), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int exp_seq[4];
    int nb, nbw, ka;
    bit saw_low, hold_a, hold_b;

    phase       = "init";
    rst         = 1'b1;
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    bus.hz_addr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("init/a_ready_in_rst", 64'(bus.a_ready), 64'd0);
    chk("init/rf_we_in_rst",   64'(bus.rf_we),   64'd0);
    rst = 1'b0;

    // Reset with A entries queued, then a basic write
    phase = "basic";
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'hAAAA0003; cycle();
    bus.a_addr = 5'd6; bus.a_data = 32'hAAAA0006; cycle();
    async_reset();
    cycle(); cycle();
    chk("basic/idle_after_rst", 64'(bus.idle), 64'd1);
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'h11111111; cycle();
    bus.a_valid = 1'b0; cycle();
    chk("basic/rf_we",   64'(bus.rf_we),   64'd1);
    chk("basic/rf_addr", 64'(bus.rf_addr), 64'd3);
    chk("basic/rf_data", 64'(bus.rf_data), 64'h11111111);
    cycle();
    chk("basic/idle_end", 64'(bus.idle), 64'd1);

    // Contention from a clean round-robin state: A first, then alternating
    phase = "rr";
    async_reset();
    bus.a_valid = 1'b1; bus.a_addr = 5'd1; bus.a_data = 32'hA1;
    bus.b_valid = 1'b1; bus.b_addr = 5'd4; bus.b_data = 32'hB4; cycle();
    bus.a_addr = 5'd2; bus.a_data = 32'hA2;
    bus.b_addr = 5'd5; bus.b_data = 32'hB5; cycle();
    drive_idle();
    exp_seq = '{1, 4, 2, 5};
    for (int k = 0; k < 4; k++) begin
      chk("rr/seq_we",   64'(bus.rf_we),   64'd1);
      chk("rr/seq_addr", 64'(bus.rf_addr), 64'(exp_seq[k]));
      cycle();
    end
    chk("rr/idle_end", 64'(bus.idle), 64'd1);

    // Backpressure on B while A keeps the arbiter busy
    phase = "bp"; nb = 0; nbw = 0; ka = 0; saw_low = 0;
    bus.b_addr = 5'd20; bus.b_data = 32'hB0000020;
    bus.a_addr = 5'd10; bus.a_data = 32'hA0000000;
    for (int c = 0; c < 14; c++) begin
      bus.a_valid = 1'b1;
      bus.b_valid = (nb < 3);
      cycle();
      if (acc_a) begin ka++; bus.a_addr = 5'(10 + (ka % 8)); bus.a_data = 32'hA0000000 + 32'(ka); end
      if (acc_b) begin nb++; bus.b_addr = 5'(20 + nb); bus.b_data = 32'hB0000020 + 32'(nb); end
      if (bus.b_valid && !bus.b_ready) saw_low = 1'b1;
      if (bus.rf_we && bus.rf_addr >= 5'd20) nbw++;
    end
    drive_idle();
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (bus.rf_we && bus.rf_addr >= 5'd20) nbw++;
    end
    chk("bp/b_ready_low_seen", 64'(saw_low), 64'd1);
    chk("bp/b_writes",         64'(nbw),     64'd3);

    // Address-0 drop and counter saturation
    phase = "drop";
    async_reset();
    bus.a_valid = 1'b1; bus.a_addr = 5'd0; bus.a_data = 32'hDEAD; cycle();
    bus.a_addr = 5'd7; bus.a_data = 32'h7; cycle();
    drive_idle();
    chk("drop/we_low",  64'(bus.rf_we),    64'd0);
    chk("drop/cnt1",    64'(bus.drop_cnt), 64'd1);
    cycle();
    chk("drop/we_7",    64'(bus.rf_we),    64'd1);
    chk("drop/addr_7",  64'(bus.rf_addr),  64'd7);
    for (int k = 0; k < 256; k++) begin
      bus.a_valid = 1'b1; bus.a_addr = 5'd0; bus.a_data = $urandom; cycle();
    end
    drive_idle();
    cycle(); cycle();
    chk("drop/sat", 64'(bus.drop_cnt), 64'd255);

    // Hazard query on a queued B write
    phase = "hz";
    async_reset();
    bus.hz_addr = 5'd9;
    bus.b_valid = 1'b1; bus.b_addr = 5'd9; bus.b_data = 32'h99; cycle();
    bus.b_valid = 1'b0;
    #1 chk("hz/queued", 64'(bus.hz_pending), 64'd1);
    cycle();
    chk("hz/rf_cycle",  64'(bus.hz_pending), 64'd1);
    cycle();
    chk("hz/after",     64'(bus.hz_pending), 64'd0);
    bus.hz_addr = 5'd0;
    bus.b_valid = 1'b1; bus.b_addr = 5'd0; bus.b_data = 32'h55; cycle();
    bus.b_valid = 1'b0;
    #1 chk("hz/zero_q", 64'(bus.hz_pending), 64'd0);
    cycle(); cycle();

    // Reset while the A FIFO is full and a write is on the port
    phase = "rst_mid";
    async_reset();
    bus.a_valid = 1'b1; bus.a_addr = 5'd11; bus.a_data = 32'h11;
    bus.b_valid = 1'b1; bus.b_addr = 5'd21; bus.b_data = 32'h21;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (acc_a) begin bus.a_addr = bus.a_addr + 5'd1; bus.a_data = bus.a_data + 32'd1; end
      if (acc_b) begin bus.b_addr = bus.b_addr + 5'd1; bus.b_data = bus.b_data + 32'd1; end
    end
    chk("rst_mid/a_full",  64'(bus.a_ready), 64'd0);
    chk("rst_mid/we_high", 64'(bus.rf_we),   64'd1);
    async_reset();
    for (int k = 0; k < 4; k++) cycle();
    chk("rst_mid/idle", 64'(bus.idle), 64'd1);

    // Random traffic; requesters hold addr/data stable until accepted
    phase = "rand"; hold_a = 0; hold_b = 0;
    for (int c = 0; c < 800; c++) begin
      if (!hold_a) begin
        bus.a_valid = ($urandom_range(0, 3) != 0);
        bus.a_addr  = 5'($urandom_range(0, 7));
        bus.a_data  = $urandom;
      end
      if (!hold_b) begin
        bus.b_valid = ($urandom_range(0, 2) != 0);
        bus.b_addr  = 5'($urandom_range(0, 7));
        bus.b_data  = $urandom;
      end
      bus.hz_addr = 5'($urandom_range(0, 7));
      cycle();
      hold_a = bus.a_valid && !acc_a;
      hold_b = bus.b_valid && !acc_b;
      if ($urandom_range(0, 149) == 0) begin
        async_reset();
        hold_a = 0;
        hold_b = 0;
      end
    end
    drive_idle();
    for (int c = 0; c < 6; c++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regs_wr_arbiter.md
Name: regs_wr_arbiter

Overview:
- Shares the register file's single write port (write enable, 5-bit write address, 32-bit write data) between two writeback requesters.
- Requester A is the ALU writeback path; requester B is the memory-load writeback path.
- Each requester has a small FIFO with a valid/ready handshake. A round-robin arbiter drains both FIFOs into one registered write-port stage.
- A combinational hazard query tells the stall logic when a register still has a write in flight.

Parameters:
- DEPTH, 2, entries per requester FIFO; power of two, minimum 2.
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- a_valid  in  1  requester A presents a write.
- a_ready  out  1  A FIFO can accept.
- a_addr  in  AW  A target register.
- a_data  in  DW  A write data.
- b_valid  in  1  requester B presents a write.
- b_ready  out  1  B FIFO can accept.
- b_addr  in  AW  B target register.
- b_data  in  DW  B write data.
- rf_we  out  1  register-file write enable.
- rf_addr  out  AW  register-file write address.
- rf_data  out  DW  register-file write data.
- hz_addr  in  AW  register being queried by the stall logic.
- hz_pending  out  1  hz_addr has an outstanding write.
- idle  out  1  both FIFOs empty and rf_we low.
- drop_cnt  out  8  count of writes discarded because their address was 0; saturates at 255.

Behaviour:
- Reset (asynchronous, rst high):
  - Both FIFOs emptied; read/write pointers and occupancy counts cleared.
  - rf_we=0, rf_addr=0, rf_data=0, drop_cnt=0.
  - Round-robin state set to last_grant=B, so A wins the first contested cycle.
  - a_ready and b_ready forced to 0 while rst is high.
  - Reset mid-operation discards all queued writes; nothing is written after rst rises.
- Handshake:
  - x_ready = !full_x (x is A or B). Ready never depends on x_valid or on a same-cycle pop, so a full FIFO accepts nothing even when popping that cycle.
  - A transfer occurs on an edge where x_valid && x_ready. The entry {addr, data} is stored at the tail.
  - Holding x_valid with ready low is legal; the requester must keep addr and data stable until the transfer.
- Arbitration, evaluated every cycle on the FIFO heads:
  - Only A non-empty: grant A. Only B non-empty: grant B.
  - Both non-empty: grant the side that is not last_grant. last_grant updates to the winner on each grant.
  - At most one pop per cycle in total.
- Output stage, registered:
  - On an edge with a grant, the head is popped and the winner's head is loaded into rf_addr/rf_data.
  - rf_we is loaded as 1 if the head address is non-zero, else 0.
  - Address-0 heads are popped, rf_we=0, and drop_cnt increments (saturating).
  - With no grant, rf_we is loaded 0; rf_addr and rf_data hold their previous values.
- Latency: a write accepted at edge N is popped at edge N+1 at the earliest, drives rf_we during cycle N+1, and is committed by the register file at edge N+2. Sustained throughput is one write per cycle.
- Ordering:
  - Per-requester order is preserved.
  - There is no ordering guarantee between A and B for the same address. Producers must not issue conflicting writes to the same register from both sides without a stall.
- Simultaneous push and pop on the same FIFO: both take effect and occupancy is unchanged.
- Pointers wrap modulo DEPTH; occupancy ranges 0..DEPTH.
- hz_pending (combinational) is 1 when hz_addr != 0 and either:
  - any valid FIFO entry has addr == hz_addr, or
  - rf_we && rf_addr == hz_addr.
  - hz_addr == 0 always gives 0.
- idle (combinational) is 1 when both FIFOs are empty and rf_we == 0.

Test Plan:
- Reset and basic write: assert rst with A holding 2 entries, release; then push A {addr 3, data 0x11111111} -> FIFO entries lost, all outputs 0, a_ready=b_ready=1, and rf_we=1/rf_addr=3/rf_data=0x11111111 exactly one cycle after acceptance, idle=1 after.
- Contention round-robin: push A {1,0xA1},{2,0xA2} and B {4,0xB4},{5,0xB5} on the same edges -> rf writes in order A1, B4, A2, B5 on four consecutive cycles, no bubbles.
- Full/backpressure: DEPTH=2, hold b_valid for 3 writes with the A FIFO kept busy so B loses arbitration -> b_ready=0 after 2 accepts, the third write is accepted only after a B pop, and no entry is lost or duplicated.
- Address 0 drop: push A {0,0xDEAD} then {7,0x7} -> rf_we low in the first drain cycle, drop_cnt=1, then rf_we=1 for addr 7. 256 zero-address writes -> drop_cnt=255.
- Hazard query: queue B {9,0x99}; hz_addr=9 -> hz_pending=1 while queued and during the rf_we cycle, 0 the cycle after; hz_addr=0 -> 0 throughout.
- Reset mid-drain: A FIFO full and rf_we=1, rst pulsed asynchronously between edges -> rf_we drops immediately, no subsequent writes, idle=1 after rst falls.
